// File: rtl/cc1200_pkg.sv
// Constants shared by the CC1200 transmit/receive sample paths.
// The transmit FIFO and the receive unpacker both import this package.
package cc1200_pkg;

    localparam int CC1200_SAMPLE_W    = 12;
    localparam int CC1200_PKT_SAMPLES = 8;

endpackage

// File: rtl/cc1200_sample_ram.sv
// Sample storage: register array with one write port and one asynchronous read port.
module cc1200_sample_ram #(
    parameter int DEPTH = 64,
    parameter int DW    = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cc1200_tx_sample_fifo.sv
// Show-ahead staging FIFO for 12-bit TX samples feeding the CC1200 SPI transmit path.
// GetDataEn flags that a whole packet is buffered so a started packet never starves.
module cc1200_tx_sample_fifo
    import cc1200_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int DW          = CC1200_SAMPLE_W,
    parameter int PKT_SAMPLES = CC1200_PKT_SAMPLES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   Flush,
    input  logic                   WrEn,
    input  logic [DW-1:0]          WrData,
    output logic                   WrReady,
    output logic                   GetDataEn,
    output logic [DW-1:0]          GetData,
    input  logic                   Next_data,
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Overflow,
    output logic                   Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          ovf;
    logic          unf;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [DW-1:0] rd_data;

    always_comb begin
        full  = (level == LW'(DEPTH));
        empty = (level == '0);
        push  = WrEn && !full;
        pop   = Next_data && !empty;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
            // Full drops the push even when a pop frees a slot this cycle.
            if (WrEn && full)       ovf <= 1'b1;
            if (Next_data && empty) unf <= 1'b1;
        end
    end

    cc1200_sample_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (push && !Flush),
        .waddr (wr_ptr),
        .wdata (WrData),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign WrReady   = !full;
    assign GetDataEn = (level >= LW'(PKT_SAMPLES));
    assign GetData   = empty ? '0 : rd_data;
    assign Level     = level;
    assign Overflow  = ovf;
    assign Underflow = unf;

endmodule

// File: tb/tb_cc1200_tx_sample_fifo.sv
// Directed bench for cc1200_tx_sample_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal checks at the points of interest.
module tb_cc1200_tx_sample_fifo;

    localparam int DEPTH = 64;
    localparam int DW    = 12;
    localparam int PKT   = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          Flush = 1'b0;
    logic          WrEn = 1'b0;
    logic [DW-1:0] WrData = '0;
    logic          WrReady;
    logic          GetDataEn;
    logic [DW-1:0] GetData;
    logic          Next_data = 1'b0;
    logic [6:0]    Level;
    logic          Overflow;
    logic          Underflow;

    int n_checks = 0;
    int n_fail   = 0;

    cc1200_tx_sample_fifo #(
        .DEPTH       (DEPTH),
        .DW          (DW),
        .PKT_SAMPLES (PKT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .Flush     (Flush),
        .WrEn      (WrEn),
        .WrData    (WrData),
        .WrReady   (WrReady),
        .GetDataEn (GetDataEn),
        .GetData   (GetData),
        .Next_data (Next_data),
        .Level     (Level),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored samples plus two sticky bits.
    int unsigned q[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (Flush) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            int  n;
            bit  do_pop;
            bit  do_push;
            n       = q.size();
            do_pop  = Next_data && (n != 0);
            do_push = WrEn && (n < DEPTH);
            if (WrEn && n == DEPTH) m_ovf = 1'b1;
            if (Next_data && n == 0) m_unf = 1'b1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(int'(WrData));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("cyc_level",     int'(Level),     n);
        chk("cyc_wrready",   int'(WrReady),   (n < DEPTH) ? 1 : 0);
        chk("cyc_getdataen", int'(GetDataEn), (n >= PKT) ? 1 : 0);
        chk("cyc_getdata",   int'(GetData),   (n != 0) ? int'(q[0]) : 0);
        chk("cyc_overflow",  int'(Overflow),  int'(m_ovf));
        chk("cyc_underflow", int'(Underflow), int'(m_unf));
    end

    task automatic step(input bit wr, input int wd, input bit nd, input bit fl);
        WrEn      = wr;
        WrData    = DW'(wd);
        Next_data = nd;
        Flush     = fl;
        @(posedge clk);
        #1;
        WrEn      = 1'b0;
        Next_data = 1'b0;
        Flush     = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wrready",   int'(WrReady),   1);
        chk("rst_getdataen", int'(GetDataEn), 0);
        chk("rst_getdata",   int'(GetData),   0);
        chk("rst_level",     int'(Level),     0);
        chk("rst_overflow",  int'(Overflow),  0);
        chk("rst_underflow", int'(Underflow), 0);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Push 0x001..0x007, then the 8th.
        for (int i = 1; i <= 7; i++) step(1'b1, i, 1'b0, 1'b0);
        chk("p7_level",     int'(Level),     7);
        chk("p7_getdataen", int'(GetDataEn), 0);
        chk("p7_getdata",   int'(GetData),   'h001);
        step(1'b1, 8, 1'b0, 1'b0);
        chk("p8_level",     int'(Level),     8);
        chk("p8_getdataen", int'(GetDataEn), 1);

        // Pop eight single-cycle strobes.
        for (int i = 1; i <= 8; i++) begin
            chk("pop_head", int'(GetData), i);
            step(1'b0, 0, 1'b1, 1'b0);
            if (i == 1) chk("pop1_getdataen", int'(GetDataEn), 0);
        end
        chk("pop8_getdata", int'(GetData), 0);
        chk("pop8_level",   int'(Level),   0);

        // Fill to 64, then push with a simultaneous pop while full.
        for (int i = 0; i < 64; i++) step(1'b1, 'h100 + i, 1'b0, 1'b0);
        chk("full_level",   int'(Level),   64);
        chk("full_wrready", int'(WrReady), 0);
        step(1'b1, 'hABC, 1'b1, 1'b0);
        chk("ovf_level",     int'(Level),     63);
        chk("ovf_flag",      int'(Overflow),  1);
        chk("ovf_wrready",   int'(WrReady),   1);
        chk("ovf_getdata",   int'(GetData),   'h101);
        chk("ovf_underflow", int'(Underflow), 0);

        // Empty: push and pop in the same cycle.
        step(1'b0, 0, 1'b0, 1'b1);
        chk("flush_ovf", int'(Overflow), 0);
        step(1'b1, 'h5A5, 1'b1, 1'b0);
        chk("e_level",     int'(Level),     1);
        chk("e_getdata",   int'(GetData),   'h5A5);
        chk("e_underflow", int'(Underflow), 1);

        // Wrap-around traffic kept roughly between 30 and 60 entries.
        step(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 45; i++) step(1'b1, $urandom & 'hFFF, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            bit wr;
            bit rd;
            int n;
            n  = q.size();
            wr = ($urandom % 2) == 1;
            rd = ($urandom % 2) == 1;
            if (n < 32) begin wr = 1'b1; rd = ($urandom % 4) == 0; end
            if (n > 58) begin rd = 1'b1; wr = ($urandom % 4) == 0; end
            step(wr, $urandom & 'hFFF, rd, 1'b0);
        end

        // Flush with push and pop at level 20, sticky flag set beforehand.
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("pre_unf", int'(Underflow), 1);
        for (int i = 0; i < 20; i++) step(1'b1, 'h200 + i, 1'b0, 1'b0);
        chk("l20_level", int'(Level), 20);
        step(1'b1, 'h777, 1'b1, 1'b1);
        chk("fl_level",     int'(Level),     0);
        chk("fl_getdata",   int'(GetData),   0);
        chk("fl_getdataen", int'(GetDataEn), 0);
        chk("fl_wrready",   int'(WrReady),   1);
        chk("fl_underflow", int'(Underflow), 0);
        step(1'b1, 'h3C3, 1'b0, 1'b0);
        chk("fl_next_push", int'(GetData), 'h3C3);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10; i++) step(1'b1, 'h400 + i, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        WrEn   = 1'b1;
        WrData = DW'('h444);
        #2 rstn = 1'b0;
        #1;
        chk("arst_level",     int'(Level),     0);
        chk("arst_getdata",   int'(GetData),   0);
        chk("arst_getdataen", int'(GetDataEn), 0);
        chk("arst_wrready",   int'(WrReady),   1);
        chk("arst_overflow",  int'(Overflow),  0);
        @(posedge clk);
        #1;
        WrEn = 1'b0;
        chk("arst_no_push", int'(Level), 0);
        #2 rstn = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 'h321, 1'b0, 1'b0);
        chk("arst_next_getdata", int'(GetData), 'h321);
        chk("arst_next_level",   int'(Level),   1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
